// File: rtl/cvs_output_sequencer_if.sv
// Control/status bundle between top-level control and the CVS output sequencer.
// master: control side (drives start/stop/mask/osc status, observes enables).
// slave:  sequencer side (observes control, drives enables and status flags).
interface cvs_output_sequencer_if #(
    parameter int NUM_CH = 5
) ();
    logic              start;
    logic              stop;
    logic [NUM_CH-1:0] ch_mask;
    logic              osc_ok;
    logic              fault_clear;
    logic [NUM_CH-1:0] ch_enable;
    logic              busy;
    logic              all_on;
    logic              fault;
    logic [2:0]        state;

    modport master (
        output start,
        output stop,
        output ch_mask,
        output osc_ok,
        output fault_clear,
        input  ch_enable,
        input  busy,
        input  all_on,
        input  fault,
        input  state
    );

    modport slave (
        input  start,
        input  stop,
        input  ch_mask,
        input  osc_ok,
        input  fault_clear,
        output ch_enable,
        output busy,
        output all_on,
        output fault,
        output state
    );
endinterface

// File: rtl/cvs_output_sequencer.sv
// Purpose: ramps the CVS output channel enables on/off one at a time, STEP_CYCLES apart.
// Latency: all outputs registered; channel k changes (k+1)*STEP_CYCLES edges after accept.
// Backpressure: none; start/stop are level-sampled, oscillator loss forces all channels off.
//
// Ports:
//   clock_i  - system clock, rising edge
//   reset_i  - synchronous active-high reset
//   ctrl_if  - slave side of cvs_output_sequencer_if:
//              in : start, stop, ch_mask, osc_ok, fault_clear
//              out: ch_enable, busy, all_on, fault, state (IDLE=0 RAMP_UP=1 ON=2 RAMP_DOWN=3 FAULT=4)
module cvs_output_sequencer #(
    parameter int NUM_CH      = 5,
    parameter int STEP_CYCLES = 16
) (
    input  logic                   clock_i,
    input  logic                   reset_i,
    cvs_output_sequencer_if.slave  ctrl_if
);

    localparam int CNT_W = $clog2(STEP_CYCLES + 1);
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STEP_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_CH - 1);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RAMP_UP   = 3'd1,
        S_ON        = 3'd2,
        S_RAMP_DOWN = 3'd3,
        S_FAULT     = 3'd4
    } state_t;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [NUM_CH-1:0] mask_q, mask_d;
    logic [NUM_CH-1:0] en_q, en_d;
    logic              busy_q, busy_d;
    logic              all_on_q, all_on_d;
    logic              fault_q, fault_d;
    logic              step_done;

    // Next-state logic. Oscillator loss is checked first in every active
    // state so it overrides stop and any step completing on the same edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        mask_d    = mask_q;
        en_d      = en_q;
        step_done = (cnt_q == CNT_LAST);

        case (state_q)
            S_IDLE: begin
                // stop wins over a simultaneous start
                if (ctrl_if.start && !ctrl_if.stop) begin
                    if (ctrl_if.osc_ok) begin
                        state_d = S_RAMP_UP;
                        idx_d   = '0;
                        cnt_d   = '0;
                        mask_d  = ctrl_if.ch_mask;
                    end else begin
                        state_d = S_FAULT;
                        en_d    = '0;
                    end
                end
            end

            S_RAMP_UP: begin
                if (!ctrl_if.osc_ok) begin
                    state_d = S_FAULT;
                    en_d    = '0;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (ctrl_if.stop) begin
                    // The channel currently being timed is abandoned; ramp down
                    // only what has already been processed.
                    cnt_d = '0;
                    if (idx_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d = S_RAMP_DOWN;
                        idx_d   = idx_q - IDX_W'(1);
                    end
                end else if (step_done) begin
                    // Masked channels still consume a full step so the
                    // schedule does not depend on the mask.
                    en_d[idx_q] = mask_q[idx_q];
                    cnt_d       = '0;
                    if (idx_q == IDX_LAST) begin
                        state_d = S_ON;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_ON: begin
                if (!ctrl_if.osc_ok) begin
                    state_d = S_FAULT;
                    en_d    = '0;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (ctrl_if.stop) begin
                    state_d = S_RAMP_DOWN;
                    idx_d   = IDX_LAST;
                    cnt_d   = '0;
                end
            end

            S_RAMP_DOWN: begin
                if (!ctrl_if.osc_ok) begin
                    state_d = S_FAULT;
                    en_d    = '0;
                    cnt_d   = '0;
                    idx_d   = '0;
                end else if (step_done) begin
                    en_d[idx_q] = 1'b0;
                    cnt_d       = '0;
                    if (idx_q == '0) begin
                        state_d = S_IDLE;
                    end else begin
                        idx_d = idx_q - IDX_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            S_FAULT: begin
                // Clearing is only honoured once the oscillator is back.
                if (ctrl_if.fault_clear && ctrl_if.osc_ok) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                en_d    = '0;
                cnt_d   = '0;
                idx_d   = '0;
            end
        endcase

        // Status flags are decoded from the next state and then registered,
        // so they line up with the state output.
        busy_d   = (state_d == S_RAMP_UP) || (state_d == S_ON) || (state_d == S_RAMP_DOWN);
        all_on_d = (state_d == S_ON);
        fault_d  = (state_d == S_FAULT);
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            idx_q    <= '0;
            mask_q   <= '0;
            en_q     <= '0;
            busy_q   <= 1'b0;
            all_on_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            mask_q   <= mask_d;
            en_q     <= en_d;
            busy_q   <= busy_d;
            all_on_q <= all_on_d;
            fault_q  <= fault_d;
        end
    end

    assign ctrl_if.ch_enable = en_q;
    assign ctrl_if.busy      = busy_q;
    assign ctrl_if.all_on    = all_on_q;
    assign ctrl_if.fault     = fault_q;
    assign ctrl_if.state     = state_q;

endmodule

// File: tb/tb_cvs_output_sequencer.sv
// Bench for cvs_output_sequencer: elapsed-time model plus directed scenarios.
// Inputs change on the falling edge; outputs are compared on the falling edge.
module tb_cvs_output_sequencer;

    localparam int NUM_CH = 5;
    localparam int STEP   = 16;

    logic clk;
    logic rst;

    cvs_output_sequencer_if #(.NUM_CH(NUM_CH)) seq_if ();

    cvs_output_sequencer #(
        .NUM_CH      (NUM_CH),
        .STEP_CYCLES (STEP)
    ) dut (
        .clock_i (clk),
        .reset_i (rst),
        .ctrl_if (seq_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // ---------------- behavioural model ----------------
    // State is tracked as phase + edges elapsed in that phase; the enabled
    // set is derived arithmetically from elapsed time.
    int         m_st    = 0;   // 0 idle,1 up,2 on,3 down,4 fault
    int         m_t     = 0;   // edges since entering ramp phase
    int         m_n     = 0;   // channels up when ramp-down began
    logic [4:0] m_mask  = '0;
    bit         m_valid = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_st = 0; m_t = 0; m_n = 0; m_mask = '0; m_valid = 1'b1;
        end else begin
            case (m_st)
                0: if (seq_if.start && !seq_if.stop) begin
                    if (seq_if.osc_ok) begin
                        m_st = 1; m_t = 0; m_mask = seq_if.ch_mask;
                    end else begin
                        m_st = 4;
                    end
                end
                1: if (!seq_if.osc_ok) m_st = 4;
                   else if (seq_if.stop) begin
                       m_n = m_t / STEP;
                       m_t = 0;
                       m_st = (m_n == 0) ? 0 : 3;
                   end else begin
                       m_t = m_t + 1;
                       if (m_t == NUM_CH * STEP) m_st = 2;
                   end
                2: if (!seq_if.osc_ok) m_st = 4;
                   else if (seq_if.stop) begin
                       m_st = 3; m_n = NUM_CH; m_t = 0;
                   end
                3: if (!seq_if.osc_ok) m_st = 4;
                   else begin
                       m_t = m_t + 1;
                       if (m_t == m_n * STEP) m_st = 0;
                   end
                default: if (seq_if.fault_clear && seq_if.osc_ok) m_st = 0;
            endcase
        end
    end

    function automatic logic [4:0] model_en();
        int up;
        case (m_st)
            1:       up = m_t / STEP;
            2:       up = NUM_CH;
            3:       up = m_n - (m_t / STEP);
            default: up = 0;
        endcase
        return m_mask & 5'((1 << up) - 1);
    endfunction

    always @(negedge clk) begin
        if (m_valid) begin
            logic [4:0] e_en;
            logic [2:0] e_st;
            logic       e_busy, e_on, e_flt;
            e_en   = model_en();
            e_st   = 3'(m_st);
            e_busy = (m_st >= 1) && (m_st <= 3);
            e_on   = (m_st == 2);
            e_flt  = (m_st == 4);
            checks++;
            if (seq_if.ch_enable !== e_en || seq_if.state !== e_st || seq_if.busy !== e_busy
                || seq_if.all_on !== e_on || seq_if.fault !== e_flt) begin
                failures++;
                $display("FAIL model_cmp t=%0t got en=%b st=%0d busy=%b on=%b flt=%b want en=%b st=%0d busy=%b on=%b flt=%b",
                         $time, seq_if.ch_enable, seq_if.state, seq_if.busy, seq_if.all_on, seq_if.fault,
                         e_en, e_st, e_busy, e_on, e_flt);
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=0x%0h want=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic pulse_start();
        seq_if.start = 1'b1; tick(1); seq_if.start = 1'b0;
    endtask

    task automatic pulse_stop();
        seq_if.stop = 1'b1; tick(1); seq_if.stop = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        seq_if.start = 1'b0; seq_if.stop = 1'b0; seq_if.ch_mask = '0;
        seq_if.osc_ok = 1'b1; seq_if.fault_clear = 1'b0;
        tick(3);
        check("reset_state", 32'(seq_if.state), 32'd0);
        check("reset_en", 32'(seq_if.ch_enable), 32'h0);
        check("reset_flags", {29'd0, seq_if.busy, seq_if.all_on, seq_if.fault}, 32'd0);
        rst = 1'b0;
        tick(2);

        // 1: full ramp-up, all channels
        seq_if.ch_mask = 5'b11111;
        pulse_start();
        check("up_accept_state", 32'(seq_if.state), 32'd1);
        tick(15);
        check("up_e15_en", 32'(seq_if.ch_enable), 32'h00);
        tick(1);
        check("up_e16_en", 32'(seq_if.ch_enable), 32'h01);
        tick(63);
        check("up_e79_en", 32'(seq_if.ch_enable), 32'h0f);
        tick(1);
        check("up_e80_en", 32'(seq_if.ch_enable), 32'h1f);
        check("up_e80_state", 32'(seq_if.state), 32'd2);
        check("up_e80_all_on", 32'(seq_if.all_on), 32'd1);

        // start in ON ignored
        seq_if.start = 1'b1; tick(3); seq_if.start = 1'b0;
        check("on_start_ignored", 32'(seq_if.state), 32'd2);

        // 2: ramp-down from ON
        pulse_stop();
        check("dn_accept_state", 32'(seq_if.state), 32'd3);
        tick(16);
        check("dn_e16_en", 32'(seq_if.ch_enable), 32'h0f);
        tick(64);
        check("dn_e80_en", 32'(seq_if.ch_enable), 32'h00);
        check("dn_e80_state", 32'(seq_if.state), 32'd0);
        check("dn_e80_busy", 32'(seq_if.busy), 32'd0);

        // 3: sparse mask, mask input changed after accept must not matter
        seq_if.ch_mask = 5'b10101;
        pulse_start();
        seq_if.ch_mask = 5'b00000;
        tick(79);
        check("mask_e79_en", 32'(seq_if.ch_enable), 32'h05);
        tick(1);
        check("mask_e80_en", 32'(seq_if.ch_enable), 32'h15);
        pulse_stop();
        tick(82);
        check("mask_down_idle", 32'(seq_if.state), 32'd0);

        // 4: stop sampled at edge 40 of ramp-up
        seq_if.ch_mask = 5'b11111;
        pulse_start();
        tick(39);
        seq_if.stop = 1'b1; tick(1); seq_if.stop = 1'b0;
        check("mid_stop_en", 32'(seq_if.ch_enable), 32'h03);
        check("mid_stop_state", 32'(seq_if.state), 32'd3);
        tick(16);
        check("mid_stop_e56_en", 32'(seq_if.ch_enable), 32'h01);
        tick(16);
        check("mid_stop_e72_en", 32'(seq_if.ch_enable), 32'h00);
        check("mid_stop_e72_state", 32'(seq_if.state), 32'd0);
        tick(2);

        // stop on the same edge a step would complete (edge 32): ch1 never rises
        pulse_start();
        tick(31);
        seq_if.stop = 1'b1; tick(1); seq_if.stop = 1'b0;
        check("stop_on_step_en", 32'(seq_if.ch_enable), 32'h01);
        tick(18);
        check("stop_on_step_idle", 32'(seq_if.state), 32'd0);

        // stop before any channel processed: straight back to IDLE
        pulse_start();
        tick(5);
        pulse_stop();
        check("early_stop_idle", 32'(seq_if.state), 32'd0);
        tick(2);

        // 5: oscillator lost in ON
        pulse_start();
        tick(82);
        seq_if.osc_ok = 1'b0; tick(1);
        check("osc_loss_en", 32'(seq_if.ch_enable), 32'h00);
        check("osc_loss_state", 32'(seq_if.state), 32'd4);
        check("osc_loss_fault", 32'(seq_if.fault), 32'd1);
        seq_if.fault_clear = 1'b1; seq_if.start = 1'b1; tick(3); seq_if.start = 1'b0;
        check("clear_no_osc", 32'(seq_if.state), 32'd4);
        seq_if.osc_ok = 1'b1; tick(1); seq_if.fault_clear = 1'b0;
        check("clear_ok_state", 32'(seq_if.state), 32'd0);
        check("clear_ok_fault", 32'(seq_if.fault), 32'd0);

        // oscillator lost mid ramp-down
        pulse_start();
        tick(80);
        pulse_stop();
        tick(20);
        seq_if.osc_ok = 1'b0; tick(1);
        check("osc_loss_dn_en", 32'(seq_if.ch_enable), 32'h00);
        seq_if.osc_ok = 1'b1; seq_if.fault_clear = 1'b1; tick(1); seq_if.fault_clear = 1'b0;

        // start with oscillator bad goes straight to FAULT
        seq_if.osc_ok = 1'b0;
        pulse_start();
        check("idle_start_bad_osc", 32'(seq_if.state), 32'd4);
        seq_if.osc_ok = 1'b1; seq_if.fault_clear = 1'b1; tick(1); seq_if.fault_clear = 1'b0;

        // 6: reset mid-ramp, then start+stop together
        pulse_start();
        tick(20);
        rst = 1'b1; tick(1); rst = 1'b0;
        check("rst_mid_en", 32'(seq_if.ch_enable), 32'h00);
        check("rst_mid_state", 32'(seq_if.state), 32'd0);
        seq_if.start = 1'b1; seq_if.stop = 1'b1; tick(2);
        seq_if.start = 1'b0; seq_if.stop = 1'b0;
        check("start_stop_idle", 32'(seq_if.state), 32'd0);
        tick(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
